serial_frame_decoder: RTL and testbench

//  Receive side of the encoder link. Consumes the 1-bit serial stream from the encoder PISO
//  and rebuilds message bytes. Line format: idle 0, start bit 1, then DATA_WIDTH data bits, LSB first.

---
 rtl/serial_frame_decoder.sv | 196 +++++++++++++++++++
 tb/tb_serial_frame_decoder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_decoder.sv
// -----------------------------------------------------------------------------
// serial_frame_decoder
//   Receive side of the encoder link. It samples the serial line once per clock
//   and rebuilds message words from frames of the form
//   (idle 0) start 1, DATA_WIDTH data bits LSB first [, even parity bit].
//   Completed words are pushed into a small first-word-fall-through FIFO.
//   The FIFO is read with a valid/ready handshake.
//
//   Optional feature macro: DECODER_PARITY_EN
//     defined   : one even-parity bit follows the data. On a mismatch the word
//                 is dropped and parityError is set (sticky).
//     undefined : no parity bit in the frame, parityError is tied low.
//
// Ports
//   clock         in   1           single clock, all state updates on posedge
//   reset         in   1           asynchronous, active-high, clears all state
//   serialIn      in   1           serial line from the encoder
//   messageOut    out  DATA_WIDTH  head-of-FIFO word, valid while messageValid
//   messageValid  out  1           FIFO not empty
//   messageReady  in   1           head word is consumed when valid && ready
//   overflow      out  1           sticky, a completed word found the FIFO full
//   parityError   out  1           sticky parity failure (feature build only)
// -----------------------------------------------------------------------------
module serial_frame_decoder #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 2   // power of 2, >= 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  serialIn,
  output logic [DATA_WIDTH-1:0] messageOut,
  output logic                  messageValid,
  input  logic                  messageReady,
  output logic                  overflow,
  output logic                  parityError
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_WIDTH - 1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef DECODER_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_PUSH   = 2'd3
  } state_t;

  // True when data plus the received parity bit has an even number of ones.
  function automatic logic even_parity_ok(input logic [DATA_WIDTH-1:0] data,
                                          input logic                  par);
    return ~((^data) ^ par);
  endfunction
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PUSH = 2'd2
  } state_t;
`endif

  state_t                  state_r;
  logic [CNT_W-1:0]        bit_cnt_r;
  logic [DATA_WIDTH-1:0]   shift_r;
  logic                    parity_err_r;

  logic [DATA_WIDTH-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W:0]          count_r;
  logic                    valid_r;
  logic                    overflow_r;

  logic                    push_s;
  logic                    pop_s;
  logic                    full_s;
  logic                    wr_en_s;
  logic                    drop_s;
  logic [PTR_W:0]          count_next_s;

  // Frame receiver: one line sample per clock, word assembled LSB first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= {CNT_W{1'b0}};
      shift_r      <= {DATA_WIDTH{1'b0}};
      parity_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (serialIn) begin
            state_r   <= ST_DATA;
            bit_cnt_r <= {CNT_W{1'b0}};
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_r[bit_cnt_r] <= serialIn;
          bit_cnt_r          <= bit_cnt_r + CNT_W'(1);
          if (bit_cnt_r == LAST_BIT) begin
`ifdef DECODER_PARITY_EN
            state_r <= ST_PARITY;
`else
            state_r <= ST_PUSH;
`endif
          end else begin
            state_r <= ST_DATA;
          end
        end
`ifdef DECODER_PARITY_EN
        ST_PARITY: begin
          // A bad word never reaches PUSH, so the FIFO is untouched.
          if (even_parity_ok(shift_r, serialIn)) begin
            state_r <= ST_PUSH;
          end else begin
            parity_err_r <= 1'b1;
            state_r      <= ST_IDLE;
          end
        end
`endif
        ST_PUSH: begin
          // The line is not looked at here; a start bit may follow next cycle.
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // FIFO control decode; a full FIFO still accepts a push when it pops that cycle.
  always_comb begin
    push_s       = (state_r == ST_PUSH);
    pop_s        = valid_r & messageReady;
    full_s       = (count_r == FULL_COUNT);
    wr_en_s      = push_s & (~full_s | pop_s);
    drop_s       = push_s & full_s & ~pop_s;
    count_next_s = count_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_next_s = count_r + (PTR_W + 1)'(1);
      2'b01:   count_next_s = count_r - (PTR_W + 1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage, pointers (wrap modulo depth), occupancy and sticky overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {(PTR_W + 1){1'b0}};
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r        <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
      count_r <= count_next_s;
      // No bypass: a word pushed into an empty FIFO shows up one edge later.
      valid_r <= (count_next_s != {(PTR_W + 1){1'b0}});
    end
  end

  assign messageOut   = mem_r[rd_ptr_r];
  assign messageValid = valid_r;
  assign overflow     = overflow_r;
`ifdef DECODER_PARITY_EN
  assign parityError  = parity_err_r;
`else
  assign parityError  = 1'b0;
  logic unused_parity_s;
  assign unused_parity_s = parity_err_r;
`endif

endmodule

// File: tb/tb_serial_frame_decoder.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_decoder
//   Directed bench for serial_frame_decoder (DATA_WIDTH=8, FIFO_DEPTH=2).
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_serial_frame_decoder;

  logic       clock;
  logic       reset;
  logic       serialIn;
  logic [7:0] messageOut;
  logic       messageValid;
  logic       messageReady;
  logic       overflow;
  logic       parityError;

  int checks;
  int errors;

  serial_frame_decoder #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .serialIn     (serialIn),
    .messageOut   (messageOut),
    .messageValid (messageValid),
    .messageReady (messageReady),
    .overflow     (overflow),
    .parityError  (parityError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start bit, data LSB first and (feature build) a correct even-parity bit.
  task automatic send_head(input logic [7:0] w);
    serialIn = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      serialIn = w[i];
      tick();
    end
`ifdef DECODER_PARITY_EN
    serialIn = ^w;
    tick();
`endif
    serialIn = 1'b0;
  endtask

  // Whole frame including the PUSH cycle.
  task automatic send_frame(input logic [7:0] w);
    send_head(w);
    tick();
  endtask

  task automatic do_reset();
    serialIn     = 1'b0;
    messageReady = 1'b0;
    reset        = 1'b1;
    tick();
    tick();
    reset        = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (messageValid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", messageValid);
    end
    checks++;
    if (messageOut !== 8'h00) begin
      errors++; $display("FAIL reset_out got %h want 00", messageOut);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL reset_overflow got %b want 0", overflow);
    end
    checks++;
    if (parityError !== 1'b0) begin
      errors++; $display("FAIL reset_parity got %b want 0", parityError);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (messageValid !== 1'b0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL idle_line cycle %0d got valid=%b ovf=%b want 0 0", i, messageValid, overflow);
      end
    end
  endtask

  // Valid must rise on the 10th edge counting the start-sample edge
  // (start, 8 data, PUSH), one more with parity, and last one cycle.
  task automatic test_single();
    logic [7:0] w;
    w = 8'hA5;
    messageReady = 1'b1;
    serialIn = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      serialIn = w[i];
      tick();
      checks++;
      if (messageValid !== 1'b0) begin
        errors++; $display("FAIL single_early bit %0d got valid=%b want 0", i, messageValid);
      end
    end
`ifdef DECODER_PARITY_EN
    serialIn = 1'b0;  // 0xA5 has four ones
    tick();
    checks++;
    if (messageValid !== 1'b0) begin
      errors++; $display("FAIL single_early parity got valid=%b want 0", messageValid);
    end
`endif
    serialIn = 1'b0;
    tick();
    checks++;
    if (messageValid !== 1'b1 || messageOut !== 8'hA5) begin
      errors++; $display("FAIL single_word got valid=%b out=%h want 1 a5", messageValid, messageOut);
    end
    tick();
    checks++;
    if (messageValid !== 1'b0) begin
      errors++; $display("FAIL single_one_cycle got valid=%b want 0", messageValid);
    end
    messageReady = 1'b0;
  endtask

  task automatic test_overflow();
    messageReady = 1'b0;
    send_frame(8'h3C);
    checks++;
    if (messageValid !== 1'b1 || messageOut !== 8'h3C) begin
      errors++; $display("FAIL ovf_first got valid=%b out=%h want 1 3c", messageValid, messageOut);
    end
    send_frame(8'h81);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_not_yet got %b want 0", overflow);
    end
    send_frame(8'hFF);
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got %b want 1", overflow);
    end
    checks++;
    if (messageValid !== 1'b1 || messageOut !== 8'h3C) begin
      errors++; $display("FAIL ovf_head got valid=%b out=%h want 1 3c", messageValid, messageOut);
    end
    messageReady = 1'b1;
    tick();
    checks++;
    if (messageValid !== 1'b1 || messageOut !== 8'h81) begin
      errors++; $display("FAIL ovf_second got valid=%b out=%h want 1 81", messageValid, messageOut);
    end
    tick();
    checks++;
    if (messageValid !== 1'b0) begin
      errors++; $display("FAIL ovf_drained got valid=%b want 0", messageValid);
    end
    messageReady = 1'b0;
    tick();
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_still_sticky got %b want 1", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    send_frame(8'h11);
    send_frame(8'h22);
    send_head(8'h33);
    messageReady = 1'b1;  // pop during the PUSH edge of the third word
    tick();
    messageReady = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL fullpp_overflow got %b want 0", overflow);
    end
    checks++;
    if (messageValid !== 1'b1 || messageOut !== 8'h22) begin
      errors++; $display("FAIL fullpp_head got valid=%b out=%h want 1 22", messageValid, messageOut);
    end
    messageReady = 1'b1;
    tick();
    checks++;
    if (messageValid !== 1'b1 || messageOut !== 8'h33) begin
      errors++; $display("FAIL fullpp_third got valid=%b out=%h want 1 33", messageValid, messageOut);
    end
    tick();
    checks++;
    if (messageValid !== 1'b0) begin
      errors++; $display("FAIL fullpp_empty got valid=%b want 0", messageValid);
    end
    messageReady = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] w;
    w = 8'h55;
    send_frame(8'h99);
    checks++;
    if (messageValid !== 1'b1 || messageOut !== 8'h99) begin
      errors++; $display("FAIL mid_prefill got valid=%b out=%h want 1 99", messageValid, messageOut);
    end
    serialIn = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      serialIn = w[i];
      tick();
    end
    reset = 1'b1;
    #1;
    checks++;
    if (messageValid !== 1'b0 || messageOut !== 8'h00) begin
      errors++; $display("FAIL mid_async_flush got valid=%b out=%h want 0 00", messageValid, messageOut);
    end
    tick();
    reset = 1'b0;
    serialIn = 1'b0;
    tick();
    send_frame(8'h12);
    checks++;
    if (messageValid !== 1'b1 || messageOut !== 8'h12) begin
      errors++; $display("FAIL mid_new_word got valid=%b out=%h want 1 12", messageValid, messageOut);
    end
    messageReady = 1'b1;
    tick();
    messageReady = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (messageValid !== 1'b0) begin
        errors++; $display("FAIL mid_no_stale cycle %0d got valid=%b out=%h want 0", i, messageValid, messageOut);
      end
    end
  endtask

`ifdef DECODER_PARITY_EN
  task automatic test_parity();
    logic [7:0] w;
    w = 8'h07;
    do_reset();
    send_frame(w);  // parity bit 1
    checks++;
    if (messageValid !== 1'b1 || messageOut !== 8'h07 || parityError !== 1'b0) begin
      errors++;
      $display("FAIL par_good got valid=%b out=%h perr=%b want 1 07 0", messageValid, messageOut, parityError);
    end
    messageReady = 1'b1;
    tick();
    messageReady = 1'b0;
    serialIn = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      serialIn = w[i];
      tick();
    end
    serialIn = 1'b0;  // wrong parity
    tick();
    tick();
    tick();
    checks++;
    if (messageValid !== 1'b0 || parityError !== 1'b1) begin
      errors++; $display("FAIL par_bad got valid=%b perr=%b want 0 1", messageValid, parityError);
    end
    send_frame(8'h0F);
    checks++;
    if (messageValid !== 1'b1 || messageOut !== 8'h0F || parityError !== 1'b1) begin
      errors++;
      $display("FAIL par_recover got valid=%b out=%h perr=%b want 1 0f 1", messageValid, messageOut, parityError);
    end
  endtask
`endif

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    serialIn     = 1'b0;
    messageReady = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_reset_midframe();
`ifdef DECODER_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
